// File: rtl/io_map_pkg.sv
// Shared IO map constants and serializer state encoding for the UART TX block.
package io_map_pkg;

    // Address bit that selects the IO space
    localparam int IO_SEL_BIT = 22;

    // Word-select bits start at addr[2]; register index n is decoded from addr[2+n]
    localparam int WORD_SEL_LSB      = 2;
    localparam int REG_LEDS_BIT      = 0;
    localparam int REG_UART_DATA_BIT = 1;
    localparam int REG_UART_CNTL_BIT = 2;

    // UART_CNTL status bit positions
    localparam int STAT_FULL_BIT = 0;
    localparam int STAT_IDLE_BIT = 1;
    localparam int STAT_OVF_BIT  = 2;

    // Writing 1 to this UART_CNTL bit clears the sticky overflow flag
    localparam int CNTL_OVF_CLR_BIT = 2;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_START = 2'd1,
        SER_DATA  = 2'd2,
        SER_STOP  = 2'd3
    } ser_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: takes a byte on valid&ready, shifts it out LSB first, DIV cycles per bit.
module uart_tx_serializer
    import io_map_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ser_idle,
    output logic       txd
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DIV - 1);

    ser_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             txd_q, txd_d;
    logic             bit_end;

    assign bit_end  = (cnt_q == BIT_LAST);
    assign ser_idle = (state_q == SER_IDLE);
    assign txd      = txd_q;

    // Next-state, baud counting and shift logic; ready only in IDLE or on the final STOP cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        tx_ready = 1'b0;
        txd_d    = 1'b1;
        case (state_q)
            SER_IDLE: begin
                tx_ready = 1'b1;
                cnt_d    = '0;
                if (tx_valid) begin
                    shreg_d = tx_byte;
                    state_d = SER_START;
                end
            end
            SER_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = SER_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SER_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = SER_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SER_STOP: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    tx_ready = 1'b1;
                    if (tx_valid) begin
                        shreg_d = tx_byte;
                        state_d = SER_START;
                    end else begin
                        state_d = SER_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = SER_IDLE;
        endcase

        // Line level follows the current state; registered so TXD is glitch-free
        case (state_q)
            SER_START: txd_d = 1'b0;
            SER_DATA:  txd_d = shreg_q[0];
            default:   txd_d = 1'b1;
        endcase
    end

    // Serializer state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= SER_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// IO register block: LED register, UART TX FIFO with overflow flag, and status decode.
module io_uart_tx
    import io_map_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] IO_mem_addr,
    input  logic [31:0] IO_mem_wdata,
    input  logic        IO_mem_wr,
    output logic [31:0] IO_mem_rdata,
    output logic [4:0]  LEDS,
    output logic        TXD
);

    localparam int DIV   = CLK_FREQ_HZ / BAUD;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [4:0]       leds_q, leds_d;
    logic             ovf_q, ovf_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];
    logic [7:0]       fifo_mem_d [FIFO_DEPTH];

    logic io_sel, sel_leds, sel_data, sel_cntl;
    logic fifo_full, fifo_empty, push, pop, ovf_evt, ovf_clr;
    logic ser_ready, ser_idle;
    logic unused_bits;

    assign io_sel   = IO_mem_addr[IO_SEL_BIT];
    assign sel_leds = io_sel & IO_mem_addr[WORD_SEL_LSB + REG_LEDS_BIT];
    assign sel_data = io_sel & IO_mem_addr[WORD_SEL_LSB + REG_UART_DATA_BIT];
    assign sel_cntl = io_sel & IO_mem_addr[WORD_SEL_LSB + REG_UART_CNTL_BIT];

    // Fullness is judged on the current count, so a same-cycle pop does not rescue a write
    assign fifo_full  = (count_q == COUNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign push       = sel_data & IO_mem_wr & ~fifo_full;
    assign ovf_evt    = sel_data & IO_mem_wr & fifo_full;
    assign ovf_clr    = sel_cntl & IO_mem_wr & IO_mem_wdata[CNTL_OVF_CLR_BIT];
    assign pop        = ser_ready & ~fifo_empty;

    assign LEDS = leds_q;

    assign unused_bits = &{1'b0, IO_mem_addr[31:23], IO_mem_addr[21:5],
                           IO_mem_addr[1:0], IO_mem_wdata[31:8]};

    // Register, FIFO pointer/count and overflow next-state
    always_comb begin
        leds_d     = leds_q;
        ovf_d      = ovf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        fifo_mem_d = fifo_mem_q;
        if (sel_leds && IO_mem_wr) begin
            leds_d = IO_mem_wdata[4:0];
        end
        if (push) begin
            fifo_mem_d[wr_ptr_q] = IO_mem_wdata[7:0];
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear keeps the flag set
        if (ovf_evt) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Control and register state with asynchronous reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            leds_q   <= 5'd0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            leds_q   <= leds_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are invalidated by the count reset, so no reset is needed here
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    // Zero-latency read mux: OR of every selected register
    always_comb begin
        IO_mem_rdata = 32'd0;
        if (sel_leds) begin
            IO_mem_rdata = IO_mem_rdata | {27'd0, leds_q};
        end
        if (sel_cntl) begin
            IO_mem_rdata[STAT_FULL_BIT] = fifo_full;
            IO_mem_rdata[STAT_IDLE_BIT] = fifo_empty & ser_idle;
            IO_mem_rdata[STAT_OVF_BIT]  = ovf_q;
            IO_mem_rdata = IO_mem_rdata | {27'd0, leds_q & {5{sel_leds}}};
        end
    end

    uart_tx_serializer #(
        .DIV (DIV)
    ) u_ser (
        .clk      (clk),
        .resetn   (resetn),
        .tx_byte  (fifo_mem_q[rd_ptr_q]),
        .tx_valid (~fifo_empty),
        .tx_ready (ser_ready),
        .ser_idle (ser_idle),
        .txd      (TXD)
    );

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed self-checking bench for io_uart_tx (DIV = 10).
module tb_io_uart_tx;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        wr = 1'b0;
    logic [31:0] rdata;
    logic [4:0]  leds;
    logic        txd;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] A_LEDS = 32'h0040_0004;
    localparam logic [31:0] A_DATA = 32'h0040_0008;
    localparam logic [31:0] A_CNTL = 32'h0040_0010;

    io_uart_tx #(
        .CLK_FREQ_HZ (1000),
        .BAUD        (100),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .IO_mem_addr  (addr),
        .IO_mem_wdata (wdata),
        .IO_mem_wr    (wr),
        .IO_mem_rdata (rdata),
        .LEDS         (leds),
        .TXD          (txd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic [31:0] exp_rdata;
        logic [4:0]  exp_leds;
    } vec_t;

    vec_t vecs [15];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        tick(1);
        wr    = 1'b0;
        wdata = 32'd0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    logic [31:0] v;
    logic [9:0]  fr;
    logic        line [200];
    logic [7:0]  b0, b1;
    logic        stable, all_high, found;
    time         t0;

    initial begin
        // Table: {addr, wdata, wr, rdata before the edge, LEDS after the edge}
        vecs[0]  = '{32'h0040_0010, 32'h0,         1'b0, 32'h2,  5'h00};
        vecs[1]  = '{32'h0040_0004, 32'h1F,        1'b1, 32'h0,  5'h1F};
        vecs[2]  = '{32'h0040_0004, 32'h0,         1'b0, 32'h1F, 5'h1F};
        vecs[3]  = '{32'h0000_0004, 32'h15,        1'b1, 32'h0,  5'h1F};
        vecs[4]  = '{32'h0000_0004, 32'h0,         1'b0, 32'h0,  5'h1F};
        vecs[5]  = '{32'h0040_0008, 32'h0,         1'b0, 32'h0,  5'h1F};
        vecs[6]  = '{32'h0040_001C, 32'h0,         1'b0, 32'h1F, 5'h1F};
        vecs[7]  = '{32'h0040_0004, 32'hFFFF_FFF4, 1'b1, 32'h1F, 5'h14};
        vecs[8]  = '{32'h0040_001C, 32'h0,         1'b0, 32'h16, 5'h14};
        vecs[9]  = '{32'h0040_0014, 32'h0,         1'b0, 32'h16, 5'h14};
        vecs[10] = '{32'h0040_000C, 32'h0,         1'b0, 32'h14, 5'h14};
        vecs[11] = '{32'h0040_0010, 32'h4,         1'b1, 32'h2,  5'h14};
        vecs[12] = '{32'h0040_0000, 32'h0,         1'b0, 32'h0,  5'h14};
        vecs[13] = '{32'h0000_0010, 32'h0,         1'b0, 32'h0,  5'h14};
        vecs[14] = '{32'h0080_0010, 32'h0,         1'b0, 32'h0,  5'h14};

        // Reset state, observed while reset is held
        tick(3);
        rd(A_CNTL, v);
        chk("rst_cntl", v, 32'h2);
        chk("rst_txd", {31'd0, txd}, 32'h1);
        chk("rst_leds", {27'd0, leds}, 32'h0);
        resetn = 1'b1;
        tick(2);

        // Register decode table
        for (int i = 0; i < 15; i++) begin
            addr  = vecs[i].addr;
            wdata = vecs[i].wdata;
            wr    = vecs[i].wr;
            #1;
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            tick(1);
            wr = 1'b0;
            chk($sformatf("vec%0d_leds", i), {27'd0, leds}, {27'd0, vecs[i].exp_leds});
        end

        // Single frame 0x55: latency and bit pattern
        bus_write(A_DATA, 32'hFFFF_FF55);
        chk("lat_edge_n", {31'd0, txd}, 32'h1);
        tick(1);
        chk("lat_edge_n1", {31'd0, txd}, 32'h1);
        rd(A_CNTL, v);
        chk("busy_cntl", v, 32'h0);
        tick(1);
        chk("lat_edge_n2", {31'd0, txd}, 32'h0);
        fr = {1'b1, 8'h55, 1'b0};
        tick(5);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("f55_bit%0d", k), {31'd0, txd}, {31'd0, fr[k]});
            if (k < 9) tick(10);
        end
        tick(6);
        rd(A_CNTL, v);
        chk("f55_idle", v, 32'h2);

        // Two queued frames back to back
        bus_write(A_DATA, 32'hA5);
        bus_write(A_DATA, 32'h3C);
        tick(1);
        for (int i = 0; i < 200; i++) begin
            line[i] = txd;
            tick(1);
        end
        chk("pair_after_200", {31'd0, txd}, 32'h1);
        chk("pair_start1", {31'd0, line[0]}, 32'h0);
        chk("pair_stop1_end", {31'd0, line[99]}, 32'h1);
        chk("pair_start2_nogap", {31'd0, line[100]}, 32'h0);
        chk("pair_stop2_end", {31'd0, line[199]}, 32'h1);
        stable = 1'b1;
        for (int j = 0; j < 20; j++)
            for (int c = 1; c < 10; c++)
                if (line[10*j + c] !== line[10*j]) stable = 1'b0;
        chk("pair_bit_width", {31'd0, stable}, 32'h1);
        for (int k = 0; k < 8; k++) begin
            b0[k] = line[10*(k+1) + 5];
            b1[k] = line[100 + 10*(k+1) + 5];
        end
        chk("pair_byte0", {24'd0, b0}, 32'hA5);
        chk("pair_byte1", {24'd0, b1}, 32'h3C);
        rd(A_CNTL, v);
        chk("pair_idle", v, 32'h2);

        // Fill FIFO while the serializer is busy, overflow, clear races
        bus_write(A_DATA, 32'h11);
        t0 = $time;
        tick(2);
        for (int i = 0; i < 9; i++) begin
            bus_write(A_DATA, 32'h20 + i);
            if (i == 6) begin
                rd(A_CNTL, v);
                chk("fill7_cntl", v, 32'h0);
            end
            if (i == 7) begin
                rd(A_CNTL, v);
                chk("fill8_full", v, 32'h1);
            end
        end
        rd(A_CNTL, v);
        chk("fill9_ovf", v, 32'h5);
        bus_write(32'h0040_0018, 32'h4);
        rd(A_CNTL, v);
        chk("ovf_clear_race", v, 32'h5);
        bus_write(A_CNTL, 32'h4);
        rd(A_CNTL, v);
        chk("ovf_cleared", v, 32'h1);
        addr  = A_CNTL;
        found = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            tick(1);
            if (rdata == 32'h2) begin
                found = 1'b1;
                break;
            end
        end
        chk("drain_idle_seen", {31'd0, found}, 32'h1);
        if (found) chk("drain_nine_frames", 32'($time - t0), 32'd9010);

        // Reset during DATA bit 3 discards the frame and the queue
        bus_write(A_LEDS, 32'h09);
        bus_write(A_DATA, 32'hC3);
        bus_write(A_DATA, 32'h81);
        tick(45);
        chk("mid_bit3_low", {31'd0, txd}, 32'h0);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_txd", {31'd0, txd}, 32'h1);
        rd(A_CNTL, v);
        chk("midrst_cntl", v, 32'h2);
        chk("midrst_leds", {27'd0, leds}, 32'h0);
        tick(2);
        resetn   = 1'b1;
        all_high = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (txd !== 1'b1) all_high = 1'b0;
        end
        chk("post_rst_line_high", {31'd0, all_high}, 32'h1);
        rd(A_CNTL, v);
        chk("post_rst_cntl", v, 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_uart_tx.md
IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate; DIV = CLK_FREQ_HZ/BAUD, truncated, and DIV >= 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries; power of two, >= 2.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port IO_mem_addr, input, 32, IO byte address from the processor.
REQ-007 SHALL have port IO_mem_wdata, input, 32, IO write data.
REQ-008 SHALL have port IO_mem_wr, input, 1, single-cycle IO write strobe.
REQ-009 SHALL have port IO_mem_rdata, output, 32, IO read data, combinational from IO_mem_addr and current state.
REQ-010 SHALL have port LEDS, output, 5, LED register.
REQ-011 SHALL have port TXD, output, 1, UART serial line, idle high.

Function
REQ-012 SHALL select the IO space only when IO_mem_addr[22]=1; otherwise rdata=0 and writes are ignored.
REQ-013 SHALL decode registers one-hot on word bits: addr[2]=LEDS, addr[3]=UART_DATA, addr[4]=UART_CNTL; rdata is the OR of all selected registers.
REQ-014 SHALL impose no read side effects; rdata valid in the same cycle as addr (zero latency).
REQ-015 SHALL, on a write to LEDS, load LEDS <= wdata[4:0] at the next edge.
REQ-016 SHALL, on a write to UART_DATA with FIFO not full, push wdata[7:0]; wdata[31:8] are ignored.
REQ-017 SHALL, on a write to UART_DATA with FIFO full (judged on the current count, even if a pop occurs in the same cycle), drop the byte and set sticky OVF.
REQ-018 SHALL, on a write to UART_CNTL with wdata[2]=1, clear OVF; a same-cycle overflow event wins and OVF stays set.
REQ-019 SHALL read UART_CNTL as {29'b0, OVF, IDLE, FULL}: IDLE = FIFO empty and serializer idle; FULL = count==FIFO_DEPTH.
REQ-020 SHALL read LEDS as {27'b0, LEDS}; UART_DATA SHALL read as 0.
REQ-021 SHALL run serializer states IDLE, START, DATA, STOP; each bit lasts exactly DIV cycles; frame is 8N1, LSB first.
REQ-022 SHALL pop in IDLE when FIFO is non-empty and enter START at the next edge; push into an empty FIFO is not popped in the same cycle.
REQ-023 SHALL fix push-to-line latency: write at edge N -> pop at edge N+1 -> TXD=0 from edge N+2.
REQ-024 SHALL, on the last cycle of STOP with FIFO non-empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
REQ-025 SHALL drive TXD=1 in IDLE and STOP, 0 in START, and the current data bit in DATA.
REQ-026 SHALL keep FIFO pointers wrapping modulo FIFO_DEPTH and a count 0..FIFO_DEPTH; simultaneous push and pop leaves count unchanged.

Reset
REQ-027 SHALL, with resetn=0, asynchronously force LEDS=0, TXD=1, FIFO empty, OVF=0, serializer IDLE, baud counter 0.
REQ-028 SHALL, on reset mid-frame, abort the frame, discard FIFO contents, and hold TXD high until new data is written after release.
REQ-029 SHALL keep IO_mem_rdata combinational during reset, reflecting the reset state (e.g. UART_CNTL reads 2).

Structure
REQ-030 SHALL place in shared package io_map_pkg: IO select bit 22, register bit indices (0,1,2), status bit positions, and the serializer state enum.
REQ-031 SHALL implement the shift and baud logic in sub-module uart_tx_serializer (inputs byte and valid; outputs ready and TXD); the FIFO and register decode stay in io_uart_tx.

Verification
REQ-032 SHALL cover: CLK_FREQ_HZ=1000, BAUD=100 (DIV=10), write 0x55 to UART_DATA at 0x400008 -> TXD low at edge N+2, bit pattern 0,1,0,1,0,1,0,1,0,1 each 10 cycles, then IDLE reads 1.
REQ-033 SHALL cover: write 9 bytes back-to-back, no pop yet -> FULL=1 after 8 pushes, 9th dropped, UART_CNTL reads 5; write 4 to UART_CNTL -> reads 1.
REQ-034 SHALL cover: queue 0xA5 and 0x3C -> two frames with no gap between stop and start, 200 cycles total, bytes decoded correctly.
REQ-035 SHALL cover: write 0x1F to 0x400004 -> LEDS=0x1F and read returns 0x1F; same write to 0x000004 -> LEDS unchanged, rdata=0.
REQ-036 SHALL cover: assert resetn=0 during DATA bit 3 of a frame -> TXD=1 immediately, UART_CNTL reads 2, no further frame after release.
REQ-037 SHALL cover: read at 0x40001C (all three selects) -> rdata = LEDS | 0 | CNTL.
